// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the commit trace stage: record kinds and field widths.
package riscv_trace_pkg;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LINK  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_BR_T  = 3'd4,
    KIND_BR_NT = 3'd5,
    KIND_JUMP  = 3'd6
  } kind_e;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned KIND_W  = 3;
  localparam int unsigned DEST_W  = 32;
  localparam int unsigned VALUE_W = 32;

  function automatic int unsigned rec_width(input int unsigned cyc_w);
    return cyc_w + PC_W + INSTR_W + KIND_W + DEST_W + VALUE_W;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous show-ahead FIFO; level is the full/empty authority and
// a push against a full FIFO without a simultaneous pop is reported as dropped.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dropped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             accept;

  assign full       = (level == LVL_W'(DEPTH));
  assign head_valid = (level != '0);
  assign pop        = head_valid && pop_ready;
  // A pop on the same edge frees the slot being written, even when full.
  assign accept     = push && (!full || pop);
  assign dropped    = push && full && !pop;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace: classifies each committed instruction, stamps it with a
// commit index and queues it for a valid/ready drainer; overflow never stalls.
module commit_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CYC_W    = 32,
  parameter int unsigned SKIP_NOP = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   commit_valid,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic                   reg_write,
  input  logic [31:0]            result,
  input  logic                   mem_write,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            rd2,
  input  logic                   branch,
  input  logic                   jump,
  input  logic [31:0]            pc_next,
  input  logic                   clear,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [CYC_W-1:0]       trc_cycle,
  output logic [31:0]            trc_pc,
  output logic [31:0]            trc_instr,
  output logic [2:0]             trc_kind,
  output logic [31:0]            trc_dest,
  output logic [31:0]            trc_value,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count,
  output logic                   overflow
);

  localparam int unsigned REC_W = rec_width(CYC_W);

  kind_e            kind;
  logic [31:0]      dest;
  logic [31:0]      value;
  logic [4:0]       rd;
  logic [CYC_W-1:0] cycle_cnt;
  logic             push;
  logic             dropped;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head_data;

  assign rd = instr[11:7];

  always_comb begin
    kind  = KIND_NONE;
    dest  = '0;
    value = '0;
    if (reg_write && rd != '0) begin
      kind  = jump ? KIND_LINK : KIND_REG;
      dest  = {27'b0, rd};
      value = result;
    end else if (mem_write) begin
      kind  = KIND_STORE;
      dest  = alu_result;
      value = rd2;
    end else if (branch) begin
      kind  = (pc_next != pc + 32'd4) ? KIND_BR_T : KIND_BR_NT;
      dest  = pc_next;
    end else if (jump) begin
      kind  = KIND_JUMP;
      dest  = pc_next;
    end
  end

  assign push = commit_valid && !((SKIP_NOP != 0) && kind == KIND_NONE);
  assign rec  = {cycle_cnt, pc, instr, kind, dest, value};

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (rec),
    .pop_ready  (trc_ready),
    .head_valid (trc_valid),
    .head_data  (head_data),
    .level      (level),
    .dropped    (dropped)
  );

  assign {trc_cycle, trc_pc, trc_instr, trc_kind, trc_dest, trc_value} = head_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (commit_valid) cycle_cnt <= cycle_cnt + CYC_W'(1);
      // clear takes precedence, so a drop on the clearing edge is not counted
      if (clear) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end else if (dropped) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH=16), with a
// second instance configured to skip KIND_NONE records.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] pc = '0, instr = '0, result = '0, alu_result = '0, rd2 = '0, pc_next = '0;
  logic        reg_write = 1'b0, mem_write = 1'b0, branch = 1'b0, jump = 1'b0;
  logic        clear = 1'b0;
  logic        trc_ready = 1'b0;
  logic        trc_ready2 = 1'b1;

  logic        trc_valid, trc_valid2;
  logic [31:0] trc_cycle, trc_cycle2, trc_pc, trc_pc2, trc_instr, trc_instr2;
  logic [2:0]  trc_kind, trc_kind2;
  logic [31:0] trc_dest, trc_dest2, trc_value, trc_value2;
  logic [4:0]  level, level2;
  logic [15:0] drop_count, drop_count2;
  logic        overflow, overflow2;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_cyc = '0;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(16), .CYC_W(32), .SKIP_NOP(0)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .pc(pc), .instr(instr),
    .reg_write(reg_write), .result(result), .mem_write(mem_write), .alu_result(alu_result),
    .rd2(rd2), .branch(branch), .jump(jump), .pc_next(pc_next), .clear(clear),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_cycle(trc_cycle), .trc_pc(trc_pc),
    .trc_instr(trc_instr), .trc_kind(trc_kind), .trc_dest(trc_dest), .trc_value(trc_value),
    .level(level), .drop_count(drop_count), .overflow(overflow)
  );

  commit_trace_buffer #(.DEPTH(16), .CYC_W(32), .SKIP_NOP(1)) dut_skip (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .pc(pc), .instr(instr),
    .reg_write(reg_write), .result(result), .mem_write(mem_write), .alu_result(alu_result),
    .rd2(rd2), .branch(branch), .jump(jump), .pc_next(pc_next), .clear(clear),
    .trc_valid(trc_valid2), .trc_ready(trc_ready2), .trc_cycle(trc_cycle2), .trc_pc(trc_pc2),
    .trc_instr(trc_instr2), .trc_kind(trc_kind2), .trc_dest(trc_dest2), .trc_value(trc_value2),
    .level(level2), .drop_count(drop_count2), .overflow(overflow2)
  );

  // One commit on the next rising edge; returns 1 time unit after that edge.
  task automatic do_commit(input logic [31:0] p, input logic [31:0] i, input logic rw,
                           input logic [31:0] res, input logic mw, input logic [31:0] alu,
                           input logic [31:0] d2, input logic br, input logic jp,
                           input logic [31:0] pn);
    commit_valid = 1'b1; pc = p; instr = i; reg_write = rw; result = res;
    mem_write = mw; alu_result = alu; rd2 = d2; branch = br; jump = jp; pc_next = pn;
    @(posedge clk); #1;
    exp_cyc = exp_cyc + 32'd1;
    commit_valid = 1'b0; reg_write = 1'b0; mem_write = 1'b0; branch = 1'b0; jump = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({trc_valid, level, drop_count, overflow} !== {1'b0, 5'd0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b level=%0d drops=%0d ovf=%b, want 0 0 0 0",
               trc_valid, level, drop_count, overflow);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reg_write;
    trc_ready = 1'b1;
    do_commit(32'h0, 32'h00700293, 1'b1, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({trc_valid, trc_kind, trc_dest, trc_value, trc_cycle, trc_pc, trc_instr} !==
        {1'b1, 3'd1, 32'd5, 32'd7, 32'd0, 32'd0, 32'h00700293}) begin
      n_fail++;
      $display("FAIL addi_record: got v=%b k=%0d d=%h val=%h cyc=%0d pc=%h i=%h, want 1 1 5 7 0 0 00700293",
               trc_valid, trc_kind, trc_dest, trc_value, trc_cycle, trc_pc, trc_instr);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({trc_valid, level} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL addi_drained: got valid=%b level=%0d, want 0 0", trc_valid, level);
    end
  endtask

  task automatic test_nop;
    do_commit(32'h4, 32'h00000013, 1'b1, 32'd0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({trc_valid, trc_kind, trc_dest, trc_value, trc_cycle} !==
        {1'b1, 3'd0, 32'd0, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL nop_record: got v=%b k=%0d d=%h val=%h cyc=%0d, want 1 0 0 0 1",
               trc_valid, trc_kind, trc_dest, trc_value, trc_cycle);
    end
    n_checks++;
    if ({trc_valid2, level2} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL nop_skipped: got valid=%b level=%0d, want 0 0", trc_valid2, level2);
    end
    do_commit(32'h8, 32'h00700293, 1'b1, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({trc_valid2, trc_kind2, trc_cycle2} !== {1'b1, 3'd1, 32'd2}) begin
      n_fail++;
      $display("FAIL skip_stamp: got v=%b k=%0d cyc=%0d, want 1 1 2", trc_valid2, trc_kind2, trc_cycle2);
    end
    n_checks++;
    if ({trc_cycle, level} !== {32'd2, 5'd1}) begin
      n_fail++;
      $display("FAIL back_to_back: got cyc=%0d level=%0d, want 2 1", trc_cycle, level);
    end
  endtask

  task automatic test_classify;
    do_commit(32'h10, 32'hFE000CE3, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h08);
    n_checks++;
    if ({trc_kind, trc_dest, trc_value, trc_cycle} !== {3'd4, 32'h08, 32'd0, 32'd3}) begin
      n_fail++;
      $display("FAIL br_taken: got k=%0d d=%h val=%h cyc=%0d, want 4 08 0 3", trc_kind, trc_dest, trc_value, trc_cycle);
    end
    do_commit(32'h10, 32'h00000463, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h14);
    n_checks++;
    if ({trc_kind, trc_dest, trc_value} !== {3'd5, 32'h14, 32'd0}) begin
      n_fail++;
      $display("FAIL br_not_taken: got k=%0d d=%h val=%h, want 5 14 0", trc_kind, trc_dest, trc_value);
    end
    do_commit(32'hFFFFFFFC, 32'h00000463, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({trc_kind, trc_dest} !== {3'd5, 32'h0}) begin
      n_fail++;
      $display("FAIL br_wrap: got k=%0d d=%h, want 5 0", trc_kind, trc_dest);
    end
    do_commit(32'h20, 32'h020000EF, 1'b1, 32'h24, 1'b0, '0, '0, 1'b0, 1'b1, 32'h40);
    n_checks++;
    if ({trc_kind, trc_dest, trc_value, trc_pc} !== {3'd2, 32'd1, 32'h24, 32'h20}) begin
      n_fail++;
      $display("FAIL jal_link: got k=%0d d=%h val=%h pc=%h, want 2 1 24 20", trc_kind, trc_dest, trc_value, trc_pc);
    end
    do_commit(32'h30, 32'h00512023, 1'b0, '0, 1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, 32'h34);
    n_checks++;
    if ({trc_kind, trc_dest, trc_value} !== {3'd3, 32'h100, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL store: got k=%0d d=%h val=%h, want 3 100 dead", trc_kind, trc_dest, trc_value);
    end
    do_commit(32'h34, 32'h04C0006F, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h80);
    n_checks++;
    if ({trc_kind, trc_dest, trc_value, trc_cycle} !== {3'd6, 32'h80, 32'd0, 32'd8}) begin
      n_fail++;
      $display("FAIL jump: got k=%0d d=%h val=%h cyc=%0d, want 6 80 0 8", trc_kind, trc_dest, trc_value, trc_cycle);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    logic [31:0] base;
    base = exp_cyc;
    trc_ready = 1'b0;
    for (int k = 0; k < 20; k++)
      do_commit(32'h100 + 32'(4 * k), 32'h00100093, 1'b1, 32'(k), 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({level, drop_count, overflow, trc_cycle} !== {5'd16, 16'd4, 1'b1, base}) begin
      n_fail++;
      $display("FAIL overflow: got level=%0d drops=%0d ovf=%b head=%0d, want 16 4 1 %0d",
               level, drop_count, overflow, trc_cycle, base);
    end
    // Full FIFO with a pop on the same edge as the push.
    trc_ready = 1'b1;
    do_commit(32'h200, 32'h00100093, 1'b1, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({level, drop_count, trc_cycle} !== {5'd16, 16'd4, base + 32'd1}) begin
      n_fail++;
      $display("FAIL full_push_pop: got level=%0d drops=%0d head=%0d, want 16 4 %0d",
               level, drop_count, trc_cycle, base + 32'd1);
    end
    for (int k = 1; k <= 16; k++) begin
      n_checks++;
      if ({trc_valid, trc_cycle} !== {1'b1, (k == 16) ? base + 32'd20 : base + 32'(k)}) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got v=%b cyc=%0d, want 1 %0d", k, trc_valid, trc_cycle,
                 (k == 16) ? base + 32'd20 : base + 32'(k));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({trc_valid, level} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL drain_empty: got v=%b level=%0d, want 0 0", trc_valid, level);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++;
    if ({drop_count, overflow} !== {16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear: got drops=%0d ovf=%b, want 0 0", drop_count, overflow);
    end
  endtask

  task automatic test_clear_vs_drop;
    trc_ready = 1'b0;
    for (int k = 0; k < 16; k++)
      do_commit(32'h300, 32'h00100093, 1'b1, 32'(k), 1'b0, '0, '0, 1'b0, 1'b0, '0);
    clear = 1'b1;
    do_commit(32'h304, 32'h00100093, 1'b1, 32'h99, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    clear = 1'b0;
    n_checks++;
    if ({level, drop_count, overflow} !== {5'd16, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_wins: got level=%0d drops=%0d ovf=%b, want 16 0 0", level, drop_count, overflow);
    end
    do_commit(32'h308, 32'h00100093, 1'b1, 32'h9A, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({drop_count, overflow} !== {16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL drop_after_clear: got drops=%0d ovf=%b, want 1 1", drop_count, overflow);
    end
  endtask

  task automatic test_async_reset;
    trc_ready = 1'b1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({trc_valid, level, drop_count, overflow} !== {1'b0, 5'd0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b level=%0d drops=%0d ovf=%b, want 0 0 0 0",
               trc_valid, level, drop_count, overflow);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    exp_cyc = '0;
    @(posedge clk); #1;
    do_commit(32'h0, 32'h00700293, 1'b1, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    n_checks++;
    if ({trc_valid, trc_cycle, trc_kind, level} !== {1'b1, 32'd0, 3'd1, 5'd1}) begin
      n_fail++;
      $display("FAIL post_reset_stamp: got v=%b cyc=%0d k=%0d level=%0d, want 1 0 1 1",
               trc_valid, trc_cycle, trc_kind, level);
    end
  endtask

  initial begin
    test_reset;
    test_reg_write;
    test_nop;
    test_classify;
    test_overflow;
    test_clear_vs_drop;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Hardware retirement-trace stage sitting directly downstream of the single-cycle core (riscv_monociclo_topo). Each cycle it samples the core's commit signals, classifies the retired instruction (register write, link, store, branch taken/not taken, jump, none) and stamps it with a commit index. The record goes into a FIFO that a debug/UART drainer empties through a valid/ready port. FIFO overflow is counted, never stalls the core.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
CYC_W, 32, width of commit-index stamp
SKIP_NOP, 0, 1 = do not enqueue KIND_NONE records (stamp still advances)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
commit_valid  in  1  an instruction retires this cycle
pc  in  32  PC of retiring instruction
instr  in  32  instruction word
reg_write  in  1  RegWrite from control unit
result  in  32  register-file write data (Result)
mem_write  in  1  MemWrite from control unit
alu_result  in  32  store address
rd2  in  32  store data
branch  in  1  Branch from control unit
jump  in  1  Jump from control unit
pc_next  in  32  next PC chosen by datapath
clear  in  1  synchronous clear of drop_count and overflow
trc_valid  out  1  head record available
trc_ready  in  1  drainer accepts head record
trc_cycle  out  CYC_W  commit index of head record
trc_pc  out  32  head PC
trc_instr  out  32  head instruction
trc_kind  out  3  head record kind
trc_dest  out  32  rd / store address / branch or jump target
trc_value  out  32  written value / store data / 0
level  out  $clog2(DEPTH)+1  entries held
drop_count  out  16  records lost to overflow, saturating
overflow  out  1  sticky: at least one drop since reset/clear

Behaviour:
- Reset (reset=0, async): pointers, level, commit counter, drop_count, overflow cleared; trc_valid=0 immediately. Storage array not reset; trc_* data outputs don't-care while trc_valid=0.
- Classification, priority order, evaluated combinationally on each commit:
  - reg_write && instr[11:7]!=0: jump ? KIND_LINK(2) : KIND_REG(1); dest={27'b0,instr[11:7]}, value=result.
  - else mem_write: KIND_STORE(3); dest=alu_result, value=rd2.
  - else branch: pc_next != pc+4 (32-bit wrap) ? KIND_BR_T(4) : KIND_BR_NT(5); dest=pc_next, value=0.
  - else jump: KIND_JUMP(6); dest=pc_next, value=0.
  - else KIND_NONE(0); dest=0, value=0.
- Commit counter: increments (wrapping mod 2^CYC_W) on every clock edge with commit_valid=1; record stamped with pre-increment value, so first commit after reset is 0. Increments even if record skipped or dropped.
- Push: commit_valid=1 and not (SKIP_NOP && kind==NONE). Accepted if level<DEPTH or a pop occurs on the same edge.
- Pop: trc_valid && trc_ready.
- Latency: record sampled on edge N visible at trc_* after edge N (one cycle); show-ahead, head outputs read combinationally from storage at read pointer.
- Simultaneous push+pop: level unchanged, including at full and at empty+push (empty: pop impossible, level 0->1).
- Drop: push while full without pop; record discarded, overflow<=1, drop_count+1 saturating at 16'hFFFF.
- clear: drop_count<=0, overflow<=0; wins over a drop on the same edge (that drop not counted). FIFO contents untouched.
- Pointers $clog2(DEPTH) bits, wrap naturally; level is the full/empty authority.
- trc_* stable while trc_valid && !trc_ready.

Decomposition:
- Package riscv_trace_pkg: KIND_* constants (3-bit), record field widths, total record width (CYC_W+32+32+3+32+32).
- Sub-module trace_fifo: generic sync FIFO, show-ahead, parameterised WIDTH/DEPTH, outputs level; classifier and counters stay in commit_trace_buffer.

Test Plan:
- Reset, commit pc=0 instr=0x00700293 (addi x5,x0,7) reg_write=1 result=7, trc_ready=1 -> next cycle trc_valid=1 kind=1 dest=5 value=7 cycle=0 pc=0, then level=0.
- Commit instr=0x00000013 reg_write=1 rd=0 -> SKIP_NOP=0: kind=0; SKIP_NOP=1: no record, next commit stamped 1.
- Branch pc=0x10 pc_next=0x08 -> kind=4 dest=0x08; pc=0x10 pc_next=0x14 -> kind=5; jal x1 pc=0x20 pc_next=0x40 result=0x24 -> kind=2 dest=1 value=0x24.
- trc_ready=0, 20 consecutive commits, DEPTH=16 -> level=16, drop_count=4, overflow=1; drain yields cycle 0..15 in order; pulse clear -> drop_count=0, overflow=0.
- Full FIFO, commit with trc_ready=1 same edge -> level stays 16, drop_count unchanged, new record appears at tail.
- reset low mid-drain -> trc_valid=0 without clock edge, level=0; after release, first commit stamped 0.
